// File: rtl/bids22_result_log.sv
// bids22_result_log: classifies auction round results, queues one record per round
// in a first-word-fall-through FIFO and keeps saturating win/revenue statistics.
module bids22_result_log #(
   parameter int DEPTH = 8,
   parameter int AMT_W = 32,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     roundOver,
   input  logic                     X_win,
   input  logic                     Y_win,
   input  logic                     Z_win,
   input  logic [1:0]               err,
   input  logic [AMT_W-1:0]         maxBid,
   input  logic                     clear,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [1:0]               out_winner,
   output logic [AMT_W-1:0]         out_amount,
   output logic [CNT_W-1:0]         out_seq,
   output logic [CNT_W-1:0]         X_wins,
   output logic [CNT_W-1:0]         Y_wins,
   output logic [CNT_W-1:0]         Z_wins,
   output logic [AMT_W-1:0]         total_revenue,
   output logic [$clog2(DEPTH):0]   fill,
   output logic                     overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int RW = 2 + AMT_W + CNT_W;

   logic [RW-1:0]    mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CNT_W-1:0] seq;
   logic             ro_q, event_s, one_hot, valid_ev, full, pop, push;
   logic [1:0]       winner;
   logic [AMT_W-1:0] amount;
   logic [AMT_W:0]   rev_sum;

   // x^y^z is true for one or three bits set; exclude the all-set case
   assign one_hot  = (X_win ^ Y_win ^ Z_win) & ~(X_win & Y_win & Z_win);
   assign event_s  = roundOver & ~ro_q;
   assign valid_ev = event_s & (err == 2'b00) & one_hot;
   assign winner   = !valid_ev ? 2'd0 : X_win ? 2'd1 : Y_win ? 2'd2 : 2'd3;
   assign amount   = valid_ev ? maxBid : '0;
   assign rev_sum  = {1'b0, total_revenue} + {1'b0, maxBid};
   assign full     = fill == (AW+1)'(DEPTH);
   assign out_valid = fill != '0;
   assign pop      = out_valid & out_ready;
   assign push     = event_s & (~full | pop);
   assign {out_winner, out_amount, out_seq} = out_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk)
      if (push && !clear) mem[wr_ptr] <= {winner, amount, seq};

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         ro_q          <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fill          <= '0;
         seq           <= '0;
         X_wins        <= '0;
         Y_wins        <= '0;
         Z_wins        <= '0;
         total_revenue <= '0;
         overflow      <= 1'b0;
      end else begin
         ro_q <= roundOver;
         if (clear) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fill          <= '0;
            seq           <= '0;
            X_wins        <= '0;
            Y_wins        <= '0;
            Z_wins        <= '0;
            total_revenue <= '0;
            overflow      <= 1'b0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fill <= fill + (AW+1)'(push) - (AW+1)'(pop);
            if (event_s) seq <= seq + CNT_W'(1);
            if (event_s && full && !pop) overflow <= 1'b1;
            if (winner == 2'd1 && !(&X_wins)) X_wins <= X_wins + CNT_W'(1);
            if (winner == 2'd2 && !(&Y_wins)) Y_wins <= Y_wins + CNT_W'(1);
            if (winner == 2'd3 && !(&Z_wins)) Z_wins <= Z_wins + CNT_W'(1);
            if (valid_ev) total_revenue <= rev_sum[AMT_W] ? '1 : rev_sum[AMT_W-1:0];
         end
      end
endmodule

// File: tb/tb_bids22_result_log.sv
// tb_bids22_result_log: table-driven per-cycle vectors plus hand-written FIFO,
// saturation, clear and asynchronous reset sequences for bids22_result_log.
module tb_bids22_result_log;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        roundOver = 1'b0, X_win = 1'b0, Y_win = 1'b0, Z_win = 1'b0;
   logic [1:0]  err = '0;
   logic [31:0] maxBid = '0;
   logic        clear = 1'b0, out_ready = 1'b0;
   logic        out_valid, overflow;
   logic [1:0]  out_winner;
   logic [31:0] out_amount, total_revenue;
   logic [15:0] out_seq, X_wins, Y_wins, Z_wins;
   logic [3:0]  fill;
   int          tests = 0, fails = 0;

   bids22_result_log dut (
      .clk(clk), .reset_n(reset_n), .roundOver(roundOver), .X_win(X_win), .Y_win(Y_win),
      .Z_win(Z_win), .err(err), .maxBid(maxBid), .clear(clear), .out_valid(out_valid),
      .out_ready(out_ready), .out_winner(out_winner), .out_amount(out_amount),
      .out_seq(out_seq), .X_wins(X_wins), .Y_wins(Y_wins), .Z_wins(Z_wins),
      .total_revenue(total_revenue), .fill(fill), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic v; logic [1:0] w; logic [31:0] amt; logic [15:0] sq;
      logic [15:0] xw, yw, zw; logic [31:0] rev; logic [3:0] f; logic o;
   } exp_t;

   typedef struct {
      logic ro, x, y, z; logic [1:0] er; logic [31:0] bid; logic rdy, clr;
      exp_t e;
   } vec_t;

   function automatic exp_t mk(logic v, logic [1:0] w, logic [31:0] amt, logic [15:0] sq,
                               logic [15:0] xw, logic [15:0] yw, logic [15:0] zw,
                               logic [31:0] rev, logic [3:0] f, logic o);
      exp_t e;
      e.v = v; e.w = w; e.amt = amt; e.sq = sq; e.xw = xw; e.yw = yw; e.zw = zw;
      e.rev = rev; e.f = f; e.o = o;
      return e;
   endfunction

   function automatic vec_t mv(logic ro, logic x, logic y, logic z, logic [1:0] er,
                               logic [31:0] bid, logic rdy, logic clr, exp_t e);
      vec_t t;
      t.ro = ro; t.x = x; t.y = y; t.z = z; t.er = er; t.bid = bid; t.rdy = rdy;
      t.clr = clr; t.e = e;
      return t;
   endfunction

   task automatic chk(string name, logic [63:0] got, logic [63:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
      end
   endtask

   task automatic check_all(string tag, exp_t e);
      chk({tag, ".out_valid"}, 64'(out_valid), 64'(e.v));
      chk({tag, ".out_winner"}, 64'(out_winner), 64'(e.w));
      chk({tag, ".out_amount"}, 64'(out_amount), 64'(e.amt));
      chk({tag, ".out_seq"}, 64'(out_seq), 64'(e.sq));
      chk({tag, ".X_wins"}, 64'(X_wins), 64'(e.xw));
      chk({tag, ".Y_wins"}, 64'(Y_wins), 64'(e.yw));
      chk({tag, ".Z_wins"}, 64'(Z_wins), 64'(e.zw));
      chk({tag, ".total_revenue"}, 64'(total_revenue), 64'(e.rev));
      chk({tag, ".fill"}, 64'(fill), 64'(e.f));
      chk({tag, ".overflow"}, 64'(overflow), 64'(e.o));
   endtask

   task automatic drive(logic ro, logic x, logic y, logic z, logic [1:0] er,
                        logic [31:0] bid, logic rdy, logic clr);
      roundOver = ro; X_win = x; Y_win = y; Z_win = z; err = er;
      maxBid = bid; out_ready = rdy; clear = clr;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
   endtask

   vec_t tbl[18];
   exp_t zero;

   initial begin
      zero = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[0]  = mv(1, 1, 0, 0, 0, 'h64, 0, 0, mk(1, 1, 'h64, 0, 1, 0, 0, 'h64, 1, 0));
      tbl[1]  = mv(0, 0, 0, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 1, 0, 0, 'h64, 0, 0));
      for (int i = 2; i < 7; i++)
         tbl[i] = mv(1, 0, 0, 1, 0, 'h10, 0, 0, mk(1, 3, 'h10, 1, 1, 0, 1, 'h74, 1, 0));
      tbl[7]  = mv(0, 0, 0, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 1, 0, 1, 'h74, 0, 0));
      tbl[8]  = mv(1, 0, 1, 0, 1, 'h50, 0, 0, mk(1, 0, 0, 2, 1, 0, 1, 'h74, 1, 0));
      tbl[9]  = mv(0, 0, 0, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 1, 0, 1, 'h74, 0, 0));
      tbl[10] = mv(1, 1, 1, 0, 0, 'h33, 0, 0, mk(1, 0, 0, 3, 1, 0, 1, 'h74, 1, 0));
      tbl[11] = mv(0, 0, 0, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 1, 0, 1, 'h74, 0, 0));
      tbl[12] = mv(1, 0, 0, 0, 0, 'h07, 0, 0, mk(1, 0, 0, 4, 1, 0, 1, 'h74, 1, 0));
      tbl[13] = mv(0, 0, 0, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 1, 0, 1, 'h74, 0, 0));
      tbl[14] = mv(1, 1, 0, 0, 2, 'h05, 0, 0, mk(1, 0, 0, 5, 1, 0, 1, 'h74, 1, 0));
      tbl[15] = mv(0, 0, 0, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 1, 0, 1, 'h74, 0, 0));
      tbl[16] = mv(1, 0, 1, 0, 0, 'h20, 0, 0, mk(1, 2, 'h20, 6, 1, 1, 1, 'h94, 1, 0));
      tbl[17] = mv(0, 0, 0, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 1, 1, 1, 'h94, 0, 0));

      #12;
      check_all("reset", zero);
      reset_n = 1'b1;
      step();
      check_all("post_reset", zero);

      foreach (tbl[i]) begin
         drive(tbl[i].ro, tbl[i].x, tbl[i].y, tbl[i].z, tbl[i].er, tbl[i].bid,
               tbl[i].rdy, tbl[i].clr);
         step();
         check_all($sformatf("vec%0d", i), tbl[i].e);
      end

      // fill the FIFO, then push+pop on a full FIFO, then overflow
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      step();
      check_all("clear", zero);
      for (int i = 0; i < 8; i++) begin
         drive(1, 1, 0, 0, 0, 32'(i + 1), 0, 0);
         step();
         idle();
      end
      check_all("full", mk(1, 1, 1, 0, 8, 0, 0, 36, 8, 0));
      drive(1, 1, 0, 0, 0, 9, 1, 0);
      step();
      check_all("full_push_pop", mk(1, 1, 2, 1, 9, 0, 0, 45, 8, 0));
      idle();
      drive(1, 1, 0, 0, 0, 10, 0, 0);
      step();
      check_all("overflow", mk(1, 1, 2, 1, 10, 0, 0, 55, 8, 1));
      idle();
      for (int i = 0; i < 8; i++) begin
         idle();
         check_all($sformatf("drain%0d", i), mk(1, 1, 32'(i + 2), 16'(i + 1), 10, 0, 0, 55, 4'(8 - i), 1));
         idle();
         check_all($sformatf("stall%0d", i), mk(1, 1, 32'(i + 2), 16'(i + 1), 10, 0, 0, 55, 4'(8 - i), 1));
         drive(0, 0, 0, 0, 0, 0, 1, 0);
         step();
      end
      check_all("drained", mk(0, 0, 0, 0, 10, 0, 0, 55, 0, 1));
      idle();
      check_all("empty_ready", mk(0, 0, 0, 0, 10, 0, 0, 55, 0, 1));

      // revenue saturation
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      step();
      drive(1, 1, 0, 0, 0, 'hFFFF_FFF0, 0, 0);
      step();
      idle();
      drive(1, 0, 1, 0, 0, 'h20, 0, 0);
      step();
      idle();
      check_all("rev_sat", mk(1, 1, 'hFFFF_FFF0, 0, 1, 1, 0, 'hFFFF_FFFF, 2, 0));
      drive(1, 0, 0, 1, 0, 1, 0, 0);
      step();
      idle();
      check_all("rev_hold", mk(1, 1, 'hFFFF_FFF0, 0, 1, 1, 1, 'hFFFF_FFFF, 3, 0));

      // clear beats a simultaneous event; held roundOver does not retrigger
      drive(1, 1, 0, 0, 0, 5, 0, 1);
      step();
      check_all("clear_event", zero);
      drive(1, 1, 0, 0, 0, 5, 0, 0);
      step();
      check_all("clear_held", zero);
      idle();
      drive(1, 0, 0, 1, 0, 7, 0, 0);
      step();
      check_all("after_clear", mk(1, 3, 7, 0, 0, 0, 1, 7, 1, 0));
      idle();
      drive(1, 1, 0, 0, 0, 3, 0, 0);
      step();
      idle();
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      step();
      check_all("mid_drain", mk(1, 1, 3, 1, 1, 0, 1, 10, 1, 0));

      // asynchronous reset between clock edges
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      reset_n = 1'b0;
      #1;
      check_all("async_reset", zero);
      @(negedge clk);
      reset_n = 1'b1;
      step();
      check_all("after_reset", zero);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/bids22_result_log.md
Name: bids22_result_log

Overview:
Downstream stage of the bids22 auction controller. Consumes the round-end outputs (roundOver, X_win/Y_win/Z_win, err, maxBid) once per round. Classifies each round and pushes one result record into a first-word-fall-through FIFO, drained by a host over a valid/ready handshake. Keeps running per-bidder win counts, total revenue and a round sequence number.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 2
AMT_W, 32, width of maxBid, record amount and total_revenue
CNT_W, 16, width of win counters and round sequence number

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
roundOver  in  1  round-end indication from the auction controller
X_win  in  1  X won the round
Y_win  in  1  Y won the round
Z_win  in  1  Z won the round
err  in  2  controller error code; nonzero means the round is invalid
maxBid  in  AMT_W  winning amount
clear  in  1  synchronous clear of FIFO, counters and flags
out_valid  out  1  head record available
out_ready  in  1  host accepts the head record
out_winner  out  2  00 none/invalid, 01 X, 10 Y, 11 Z
out_amount  out  AMT_W  winning amount; 0 when winner is 00
out_seq  out  CNT_W  round sequence number of the record
X_wins  out  CNT_W  rounds won by X
Y_wins  out  CNT_W  rounds won by Y
Z_wins  out  CNT_W  rounds won by Z
total_revenue  out  AMT_W  sum of valid winning amounts
fill  out  $clog2(DEPTH)+1  FIFO occupancy
overflow  out  1  sticky: a record was dropped because the FIFO was full

Behaviour:
- Reset (reset_n=0, asynchronous): all outputs 0, FIFO empty, internal roundOver_q=0, sequence counter=0.
- Event detection: an event occurs on an edge where roundOver=1 and roundOver_q=0. roundOver_q registers roundOver every cycle. A roundOver held high for several cycles gives exactly one event.
- Classification uses input values sampled at the event edge:
  - err==0 and exactly one win bit set: winner is 01 (X), 10 (Y) or 11 (Z); amount is maxBid.
  - Anything else (err!=0, zero win bits, or several win bits): winner 00, amount 0.
- Record = {winner, amount, seq}, where seq is the sequence counter before increment.
- Sequence counter increments by 1 on every event, valid or not, and wraps at 2^CNT_W.
- Counters on a valid event:
  - Matching win counter increments, saturating at 2^CNT_W-1.
  - total_revenue += maxBid, saturating at 2^AMT_W-1; no wrap.
- Invalid events change only seq and the FIFO.
- FIFO:
  - Push on event; pop when out_valid && out_ready.
  - Latency: a record pushed at edge k is visible on out_* with out_valid=1 after edge k when the FIFO was empty; no extra bubble.
  - out_* show the head entry and must stay stable while out_valid=1 && out_ready=0.
  - out_winner/out_amount/out_seq are 0 when empty.
  - Full and pop on the same edge as a push: both occur, fill unchanged, no overflow.
  - Full without pop: the record is dropped and overflow is set (sticky). Counters and seq still update.
  - Empty with out_ready=1: no effect. fill never exceeds DEPTH; read/write pointers wrap modulo DEPTH.
- clear=1 at an edge: FIFO empty, counters, seq, total_revenue and overflow go to 0.
  - clear has priority over a simultaneous event, which is discarded.
  - roundOver_q still updates, so a roundOver held high through clear does not retrigger afterwards.
- Reset mid-operation: state returns to reset values immediately; no partial record survives.

Test Plan:
- Reset, then pulse roundOver 1 cycle with X_win=1, err=0, maxBid=0x64 -> next cycle out_valid=1, out_winner=01, out_amount=0x64, out_seq=0; X_wins=1, total_revenue=0x64, fill=1.
- roundOver held high 5 cycles with Z_win=1, maxBid=0x10 -> exactly one record; Z_wins=1; seq advances by 1 only.
- Event with err=01, Y_win=1, maxBid=0x50 -> record winner=00, amount=0; Y_wins and total_revenue unchanged; seq increments.
- out_ready=0, 9 events with DEPTH=8 -> fill=8, overflow=1, X_wins counts all 9; drain 8 records with seq 0..7 in order and stable data while stalled.
- FIFO full, event and out_ready=1 on the same edge -> fill stays 8, overflow stays 0, head advances; then total_revenue near 0xFFFFFFF0 plus maxBid=0x20 -> saturates at 0xFFFFFFFF.
- clear asserted on the same edge as an event -> all counters 0, fill=0, overflow=0, no record; assert reset_n=0 mid-drain -> outputs 0 asynchronously.
